// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller: FSM state encoding
// and the bit-counter width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of a counter that indexes bits 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand and result handshakes of the bit-serial adder.
// The slave modport is the adder's view, the master modport its environment's.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;

  modport slave (
    input  valid_i, a_i, b_i, cin_i, ready_i,
    output ready_o, valid_o, sum_o, cout_o
  );

  modport master (
    output valid_i, a_i, b_i, cin_i, ready_i,
    input  ready_o, valid_o, sum_o, cout_o
  );
endinterface

// File: rtl/fulladder_sync.sv
// One-bit full adder with registered sum and carry; results appear
// one clock after the inputs are presented.
module fulladder_sync (
  input  logic clk_i,
  input  logic areset_i,
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic S_o,
  output logic Cout_o
);

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      S_o    <= 1'b0;
      Cout_o <= 1'b0;
    end else begin
      S_o    <= a_i ^ b_i ^ cin_i;
      Cout_o <= (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
    end
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through one
// registered full adder and the sum is reassembled in a shift register.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 areset_i,
  serial_adder_ctrl_if.slave   bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   opa_q, opb_q, sum_q;
  logic               cin_q, cout_q;
  logic               accept, last_bit;
  logic               fa_cin, fa_s, fa_cout;

  assign accept   = bus.valid_i && (state_q == IDLE);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // Bit 0 takes the captured carry-in; later bits chain the adder's own registered carry.
  assign fa_cin = (cnt_q == '0) ? cin_q : fa_cout;

  fulladder_sync u_fa (
    .clk_i    (clk_i),
    .areset_i (areset_i),
    .a_i      (opa_q[0]),
    .b_i      (opb_q[0]),
    .cin_i    (fa_cin),
    .S_o      (fa_s),
    .Cout_o   (fa_cout)
  );

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = RUN;
      RUN:     if (last_bit)    state_d = FLUSH;
      FLUSH:                    state_d = DONE;
      DONE:    if (bus.ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      cnt_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      cin_q  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            opa_q <= bus.a_i;
            opb_q <= bus.b_i;
            cin_q <= bus.cin_i;
            cnt_q <= '0;
          end
        end
        RUN: begin
          opa_q <= opa_q >> 1;
          opb_q <= opb_q >> 1;
          if (!last_bit) cnt_q <= cnt_q + CNT_W'(1);
          // Adder output lags the fed bit by one cycle, so nothing is captured at k==0.
          if (cnt_q != '0) sum_q <= {fa_s, sum_q[WIDTH-1:1]};
        end
        FLUSH: begin
          sum_q  <= {fa_s, sum_q[WIDTH-1:1]};
          cout_q <= fa_cout;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.valid_o = (state_q == DONE);
  assign bus.sum_o   = sum_q;
  assign bus.cout_o  = cout_q;

endmodule
